// File: rtl/counter_pkg.sv
// Shared constants and parameter-legality check for the counter block.
package counter_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;
    localparam int unsigned MIN_WIDTH     = 2;
    localparam int unsigned MAX_WIDTH     = 32;

    // True when width, terminal count and step describe a counter we can build.
    function automatic bit params_legal(
        input int unsigned     width,
        input longint unsigned max_value,
        input longint unsigned step
    );
        bit ok;
        ok = 1'b1;
        if (width < MIN_WIDTH || width > MAX_WIDTH) begin
            ok = 1'b0;
        end else if (max_value >= (64'd1 << width)) begin
            ok = 1'b0;
        end
        if (step == 64'd0 || step > max_value) begin
            ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/reset_sync.sv
// Reset synchronizer: asserts asynchronously, releases after two clk edges.
module reset_sync (
    input  logic clk_i,
    input  logic rst_ni,
    output logic rst_no
);

    logic [1:0] sync_q;

    // Shift ones in once reset is released; any low on rst_ni clears both stages.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], 1'b1};
        end
    end

    assign rst_no = sync_q[1];

endmodule

// File: rtl/counter.sv
// Free-running modulo (MAX_VALUE+1) counter advancing by STEP each clock.
module counter
    import counter_pkg::*;
#(
    parameter int unsigned     WIDTH     = DEFAULT_WIDTH,
    parameter longint unsigned MAX_VALUE = (64'd1 << WIDTH) - 64'd1,
    parameter longint unsigned STEP      = 64'd1
) (
    output logic [WIDTH-1:0] value,
    input  logic             clk,
    input  logic             reset
);

    // One extra bit so value + STEP can never overflow before the wrap test.
    localparam int unsigned SUM_W = WIDTH + 1;

    if (!params_legal(WIDTH, MAX_VALUE, STEP)) begin : g_param_check
        $error("counter: illegal parameters WIDTH=%0d MAX_VALUE=%0d STEP=%0d",
               WIDTH, MAX_VALUE, STEP);
    end

    localparam logic [SUM_W-1:0] STEP_W    = SUM_W'(STEP);
    localparam logic [SUM_W-1:0] LIMIT_W   = SUM_W'(MAX_VALUE);
    localparam logic [SUM_W-1:0] MODULUS_W = SUM_W'(MAX_VALUE + 64'd1);

    logic             run;
    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] value_d;
    logic [SUM_W-1:0] sum;

    reset_sync u_reset_sync (
        .clk_i  (clk),
        .rst_ni (reset),
        .rst_no (run)
    );

    // Next count: add STEP, fold back into 0..MAX_VALUE when it overshoots.
    always_comb begin
        value_d = value_q;
        sum     = {1'b0, value_q} + STEP_W;
        if (run) begin
            if (sum > LIMIT_W) begin
                value_d = WIDTH'(sum - MODULUS_W);
            end else begin
                value_d = WIDTH'(sum);
            end
        end
    end

    // Count register, cleared the instant reset drops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: tb/tb_counter.sv
// Directed bench for counter: default build and a WIDTH=4/MAX=9/STEP=3 build.
module tb_counter;

    logic       clk;
    logic       reset;
    logic [7:0] value_big;
    logic [3:0] value_small;

    int unsigned n_total   = 0;
    int unsigned n_bad     = 0;
    int unsigned exp_big   = 0;
    int unsigned exp_small = 0;
    int unsigned hold      = 0;

    counter dut_big (
        .value (value_big),
        .clk   (clk),
        .reset (reset)
    );

    counter #(
        .WIDTH     (4),
        .MAX_VALUE (9),
        .STEP      (3)
    ) dut_small (
        .value (value_small),
        .clk   (clk),
        .reset (reset)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic assert_reset();
        reset     = 1'b0;
        exp_big   = 0;
        exp_small = 0;
    endtask

    task automatic release_reset();
        reset = 1'b1;
        hold  = 2;
    endtask

    // Advance one rising edge and compare both counters to the reference model.
    task automatic step_check(input string tag);
        @(posedge clk);
        #1;
        if (hold > 0) begin
            hold--;
        end else begin
            exp_big   = (exp_big == 255) ? 0 : exp_big + 1;
            exp_small = (exp_small + 3 > 9) ? exp_small + 3 - 10 : exp_small + 3;
        end
        check({tag, "_big"}, 32'(value_big), 32'(exp_big));
        check({tag, "_small"}, 32'(value_small), 32'(exp_small));
    endtask

    initial begin
        assert_reset();
        #1;
        check("rst0_big", 32'(value_big), 32'd0);
        check("rst0_small", 32'(value_small), 32'd0);
        #11;
        check("rst_hold_big", 32'(value_big), 32'd0);
        check("rst_hold_small", 32'(value_small), 32'd0);
        #5;
        release_reset();

        // Expected big: 0,0,1,2,...,8 ; small: 0,0,3,6,9,2,5,8,1,4
        for (int i = 0; i < 10; i++) step_check("start");
        check("start_end_big", 32'(value_big), 32'd8);
        check("start_end_small", 32'(value_small), 32'd4);

        while (exp_big != 255) step_check("run");
        check("at_max_big", 32'(value_big), 32'd255);
        step_check("wrap");
        check("wrap0_big", 32'(value_big), 32'd0);
        step_check("wrap");
        check("wrap1_big", 32'(value_big), 32'd1);

        // Short mid-count reset pulse of 11 units, asserted between edges.
        for (int i = 0; i < 4; i++) step_check("pre_pulse");
        check("pre_pulse_big", 32'(value_big), 32'd5);
        #2;
        assert_reset();
        #1;
        check("pulse_clear_big", 32'(value_big), 32'd0);
        check("pulse_clear_small", 32'(value_small), 32'd0);
        #10;
        release_reset();
        for (int i = 0; i < 3; i++) step_check("pulse_restart");
        check("pulse_restart_big", 32'(value_big), 32'd1);
        check("pulse_restart_small", 32'(value_small), 32'd3);

        // 3-unit reset glitch between two edges.
        for (int i = 0; i < 2; i++) step_check("pre_glitch");
        #3;
        assert_reset();
        #1;
        check("glitch_clear_big", 32'(value_big), 32'd0);
        check("glitch_clear_small", 32'(value_small), 32'd0);
        #2;
        release_reset();
        for (int i = 0; i < 3; i++) step_check("glitch_restart");
        check("glitch_restart_big", 32'(value_big), 32'd1);
        check("glitch_restart_small", 32'(value_small), 32'd3);
        for (int i = 0; i < 4; i++) step_check("tail");
        check("tail_small", 32'(value_small), 32'd5);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
